// File: rtl/mm_cdr_multilane.sv
// rtl/mm_cdr_multilane.sv - parallel-lane Mueller-Muller CDR loop driving the PI code
// Optional lock detector built when MM_CDR_LOCK_DET_EN is defined.
module mm_cdr_multilane #(
  parameter int adc_bits    = 8,
  parameter int num_lanes   = 4,
  parameter int pi_ctl_bits = 8,
  parameter int pi_ctl_init = 0,
  parameter int filt_shift  = 8,
  parameter int lock_thresh = 16,
  parameter int lock_count  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [num_lanes*adc_bits-1:0] data_i,
  input  logic [4:0]                    kp_shift,
  input  logic [4:0]                    ki_shift,
  input  logic                          freeze,
  input  logic                          ext_load,
  input  logic [pi_ctl_bits-1:0]        ext_val,
  output logic [pi_ctl_bits-1:0]        pi_ctl,
  output logic                          lock
);

  localparam int W  = pi_ctl_bits + filt_shift;
  localparam int TW = adc_bits + 1;
  localparam int PW = adc_bits + 2;
  localparam int SW = adc_bits + 2 + $clog2(num_lanes);

  logic signed [adc_bits-1:0] hist_data;
  logic signed [1:0]          hist_val;
  logic signed [adc_bits-1:0] samp [num_lanes+1];
  logic signed [1:0]          sval [num_lanes+1];
  logic signed [PW-1:0]       pd_lane;
  logic signed [SW-1:0]       pd_acc;
  logic signed [SW-1:0]       pd_sum;
  logic                       s1_valid;

  logic [W-1:0]        phase_full;
  logic signed [W-1:0] freq_full;
  logic signed [W-1:0] err, kp_term, ki_term, freq_next;
  logic signed [W:0]   fsum;
  logic [W-1:0]        phase_next;

  // val is +1/-1 from the slicer, but 0 for the history right after reset
  function automatic logic signed [TW-1:0] slice_mul(input logic signed [adc_bits-1:0] d,
                                                     input logic signed [1:0] v);
    logic signed [TW-1:0] dx;
    dx = TW'(d);
    if (v == 2'sb00)
      slice_mul = '0;
    else if (v[1])
      slice_mul = -dx;
    else
      slice_mul = dx;
  endfunction

  function automatic logic signed [W-1:0] sra(input logic signed [W-1:0] x, input logic [4:0] sh);
    if ({27'b0, sh} >= W)
      sra = {W{x[W-1]}};
    else
      sra = x >>> sh;
  endfunction

  always_comb begin
    samp[0] = hist_data;
    sval[0] = hist_val;
    for (int k = 0; k < num_lanes; k++) begin
      samp[k+1] = data_i[k*adc_bits +: adc_bits];
      sval[k+1] = ($signed(data_i[k*adc_bits +: adc_bits]) > 0) ? 2'sb01 : 2'sb11;
    end
  end

  always_comb begin
    pd_lane = '0;
    pd_acc  = '0;
    for (int k = 0; k < num_lanes; k++) begin
      pd_lane = PW'(slice_mul(samp[k], sval[k+1])) - PW'(slice_mul(samp[k+1], sval[k]));
      pd_acc  = pd_acc + SW'(pd_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pd_sum    <= '0;
      s1_valid  <= 1'b0;
      hist_data <= '0;
      hist_val  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        pd_sum    <= pd_acc;
        hist_data <= samp[num_lanes];
        hist_val  <= sval[num_lanes];
      end
    end
  end

  always_comb begin
    err     = -(W'(pd_sum));
    kp_term = sra(err, kp_shift);
    ki_term = sra(err, ki_shift);
    fsum    = (W+1)'(freq_full) + (W+1)'(ki_term);
    if (fsum[W] != fsum[W-1])
      freq_next = fsum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      freq_next = fsum[W-1:0];
    // proportional path uses the pre-update integrator value
    phase_next = phase_full + $unsigned(kp_term) + $unsigned(freq_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_full <= W'(pi_ctl_init) << filt_shift;
      freq_full  <= '0;
    end else if (ext_load) begin
      phase_full <= W'(ext_val) << filt_shift;
    end else if (s1_valid && !freeze) begin
      phase_full <= phase_next;
      freq_full  <= freq_next;
    end
  end

  assign pi_ctl = phase_full[W-1:filt_shift];

`ifdef MM_CDR_LOCK_DET_EN
  localparam int CW = $clog2(lock_count + 1);

  logic [CW-1:0] lock_cnt, cnt_next;
  logic [SW-1:0] pd_abs;
  logic          quiet;

  always_comb begin
    pd_abs   = pd_sum[SW-1] ? $unsigned(-pd_sum) : $unsigned(pd_sum);
    quiet    = (pd_abs <= SW'(lock_thresh));
    cnt_next = lock_cnt;
    if (s1_valid) begin
      if (!quiet)
        cnt_next = '0;
      else if (lock_cnt != CW'(lock_count))
        cnt_next = lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else begin
      lock_cnt <= cnt_next;
      lock     <= (cnt_next == CW'(lock_count));
    end
  end
`else
  assign lock = 1'b0;
`endif

endmodule

// File: doc/mm_cdr_multilane.md
# mm_cdr_multilane

Parallel-lane Mueller-Müller timing-recovery loop for the ADC-based receiver. Accepts one word of `num_lanes` consecutive signed ADC samples per valid cycle, forms a lane-summed MM phase error, and drives the phase-interpolator code through a pipelined second-order loop filter with proportional and integral paths. It adds an external phase-load override and an optional lock detector. It sits between the ADC deserializer output and the PI control bus, replacing the single-lane, integral-only phase detector.

## Interface
- `adc_bits`, 8, ADC sample width (signed two's complement)
- `num_lanes`, 4, samples per input word; lane 0 is earliest in time
- `pi_ctl_bits`, 8, PI code width
- `pi_ctl_init`, 0, PI code loaded on reset
- `filt_shift`, 8, fractional bits below the PI code in the filter accumulators
- `lock_thresh`, 16, maximum |pd_sum| counted as "quiet" (lock detector)
- `lock_count`, 64, consecutive quiet updates required to declare lock
- `clk` input 1: sole clock; everything is on the rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: `data_i` holds a new word this cycle
- `data_i` input num_lanes×adc_bits: packed signed samples; lane k is bits [k*adc_bits +: adc_bits]
- `kp_shift` input 5: proportional gain, expressed as a right-shift amount
- `ki_shift` input 5: integral gain, expressed as a right-shift amount
- `freeze` input 1: hold both filter accumulators
- `ext_load` input 1: load the phase accumulator from `ext_val`
- `ext_val` input pi_ctl_bits: PI code loaded by `ext_load`
- `pi_ctl` output pi_ctl_bits: PI code, equal to phase_full[W-1:filt_shift]
- `lock` output 1: lock indicator

## Operation
- W = pi_ctl_bits + filt_shift. phase_full is unsigned W bits and wraps modulo 2^W. freq_full is signed W bits and saturates.
- Slicer: val[k] = +1 if data[k] > 0, else −1. Zero slices to −1.
- History: hist_data and hist_val hold lane num_lanes−1 of the last accepted word.
  - Both reset to 0.
  - Both update only when `in_valid`=1, including while `freeze`=1.
- Phase detector, with lane −1 = history: pd[k] = data[k−1]·val[k] − data[k]·val[k−1].
  - Each term is adc_bits+1 bits signed.
  - pd[k] is adc_bits+2 bits.
  - pd_sum is adc_bits+2+$clog2(num_lanes) bits; it never overflows.
- Stage 1: when `in_valid`=1, register pd_sum and set s1_valid=1. Otherwise s1_valid=0.
- Stage 2: when s1_valid=1, freeze=0 and ext_load=0, with err = −pd_sum sign-extended to W bits:
  - freq_full ← sat(freq_full + (err >>> ki_shift)), saturating to [−2^(W−1), 2^(W−1)−1]
  - phase_full ← phase_full + (err >>> kp_shift) + freq_full, using the old freq_full, modulo 2^W
- Shifts are arithmetic and round toward −∞. A shift ≥ W yields 0 or −1.
- `ext_load`=1 overrides everything:
  - phase_full ← ext_val << filt_shift
  - freq_full is unchanged
  - a simultaneous stage-2 update is discarded
- `freeze`=1 blocks accumulator updates only. The pipeline and the lock detector keep running.

## Timing
- Reset state:
  - phase_full = pi_ctl_init << filt_shift, so `pi_ctl`=pi_ctl_init
  - freq_full = 0
  - pd_sum = 0, s1_valid = 0
  - history = 0
  - lock counter = 0, `lock` = 0
- Latency: a word sampled at edge N updates `pi_ctl` visibly after edge N+1.
- `ext_load` sampled at edge N makes `pi_ctl`=ext_val after edge N.
- Back-to-back valid words are allowed. Throughput is one word per cycle; there is no backpressure.
- Gaps in `in_valid` freeze the filter. `pi_ctl` holds.
- `rst` asserted mid-stream:
  - all state returns to reset values at that edge
  - any in-flight stage-1 word is dropped

## Configuration
- `MM_CDR_LOCK_DET_EN` defined:
  - On each stage-2-eligible cycle (s1_valid=1, independent of freeze and ext_load): if |pd_sum| ≤ lock_thresh, the counter increments, saturating at lock_count. Otherwise the counter and `lock` clear.
  - `lock`=1 while counter = lock_count.
  - `lock` is registered and changes after the same edge as the counter.
- Undefined: no counter is built and `lock` is tied to 0.

## Test plan
All scenarios use defaults, kp_shift=0 and ki_shift=15 unless stated.
- Reset: hold `rst` 3 cycles with random inputs -> `pi_ctl`=0, `lock`=0. With pi_ctl_init=37 -> `pi_ctl`=37.
- Flat data: 50 valid words of all lanes +10 -> pd_sum=0 every word, `pi_ctl` stays 0.
- Single word after reset: lanes [10,−30,10,−30], then `in_valid`=0 -> pd_sum=+20, phase_full=65516, `pi_ctl`=255 two edges after the input edge and held during idle, freq_full=−1.
- Saturation: ki_shift=0, kp_shift=31, repeat a word with positive err -> freq_full climbs to +32767 and stays there with no wrap. `pi_ctl` keeps advancing and wraps 255→0.
- Load and freeze:
  - `ext_load`=1 with `ext_val`=0x80 on the same cycle as a stage-2 update -> `pi_ctl`=0x80, freq_full unchanged.
  - Then `freeze`=1 with valid traffic -> `pi_ctl` stays 0x80.
- Lock (macro defined): 64 quiet words -> `lock` rises after the 64th update. One word with |pd_sum|=200 -> `lock`=0 the next cycle. Macro undefined -> `lock` always 0.
